// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
//
// Instruction-fetch stage that feeds the processor core one instruction at a
// time through a valid/ready handshake. Holds a small program memory and a
// program counter, stops on HALT_OP and accepts PC redirects from downstream.
// While no instruction is valid, `instr` carries NOP_OP because the core
// samples `instr` every clock and an all-zero word would decode as ADD.
//
// Ports:
//   clk          in   clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   start        in   begin execution at address 0 (IDLE/HALTED only)
//   prog_we      in   program memory write enable (IDLE/HALTED only)
//   prog_addr    in   program write address
//   prog_data    in   program write data
//   instr_ready  in   downstream accepts the current instruction
//   branch_en    in   redirect the PC (FETCH/ISSUE only)
//   branch_addr  in   redirect target
//   instr        out  instruction to the core, NOP_OP when not valid
//   instr_valid  out  instr holds a real instruction
//   pc           out  current program counter
//   busy         out  state is FETCH or ISSUE
//   halted       out  state is HALTED
//   issued_count out  instructions accepted since last start, saturating
// -----------------------------------------------------------------------------
module instr_fetch_unit #(
    parameter int                 ADDR_W  = 5,
    parameter int                 DATA_W  = 8,
    parameter logic [DATA_W-1:0]  HALT_OP = 8'h13,
    parameter logic [DATA_W-1:0]  NOP_OP  = 8'hFF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              prog_we,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [DATA_W-1:0] prog_data,
    input  logic              instr_ready,
    input  logic              branch_en,
    input  logic [ADDR_W-1:0] branch_addr,
    output logic [DATA_W-1:0] instr,
    output logic              instr_valid,
    output logic [ADDR_W-1:0] pc,
    output logic              busy,
    output logic              halted,
    output logic [7:0]        issued_count
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_FETCH  = 2'd1,
        S_ISSUE  = 2'd2,
        S_HALTED = 2'd3
    } state_t;

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem_r [0:DEPTH-1];

    state_t            state_r, state_s;
    logic [ADDR_W-1:0] pc_r, pc_s;
    logic [DATA_W-1:0] instr_r, instr_s;
    logic              valid_r, valid_s;
    logic [7:0]        count_r, count_s;
    logic              busy_r, busy_s;
    logic              halted_r, halted_s;
    logic              mem_we_s;

    // Next-state and next-output logic for the fetch FSM.
    always_comb begin
        state_s  = state_r;
        pc_s     = pc_r;
        instr_s  = instr_r;
        valid_s  = valid_r;
        count_s  = count_r;
        mem_we_s = 1'b0;

        case (state_r)
            S_IDLE, S_HALTED: begin
                // Programming and start may coincide; the write lands at this
                // edge, so the fetch one cycle later already sees new data.
                mem_we_s = prog_we;
                if (start) begin
                    pc_s    = '0;
                    count_s = 8'd0;
                    state_s = S_FETCH;
                end else begin
                    state_s = state_r;
                end
            end

            S_FETCH: begin
                if (branch_en) begin
                    pc_s = branch_addr;
                end else begin
                    instr_s = mem_r[pc_r];
                    valid_s = 1'b1;
                    state_s = S_ISSUE;
                end
            end

            S_ISSUE: begin
                // A redirect wins over acceptance: the held instruction is
                // on the wrong path and must not be counted.
                if (branch_en) begin
                    pc_s    = branch_addr;
                    instr_s = NOP_OP;
                    valid_s = 1'b0;
                    state_s = S_FETCH;
                end else if (instr_ready) begin
                    count_s = (count_r == 8'd255) ? count_r : (count_r + 8'd1);
                    instr_s = NOP_OP;
                    valid_s = 1'b0;
                    if (instr_r == HALT_OP) begin
                        // PC is left pointing at the HALT.
                        state_s = S_HALTED;
                    end else begin
                        pc_s    = pc_r + {{(ADDR_W-1){1'b0}}, 1'b1};
                        state_s = S_FETCH;
                    end
                end else begin
                    state_s = S_ISSUE;
                end
            end

            default: begin
                state_s = S_IDLE;
                instr_s = NOP_OP;
                valid_s = 1'b0;
            end
        endcase

        busy_s   = (state_s == S_FETCH) || (state_s == S_ISSUE);
        halted_s = (state_s == S_HALTED);
    end

    // FSM state and registered outputs, cleared immediately on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= S_IDLE;
            pc_r     <= '0;
            instr_r  <= NOP_OP;
            valid_r  <= 1'b0;
            count_r  <= 8'd0;
            busy_r   <= 1'b0;
            halted_r <= 1'b0;
        end else begin
            state_r  <= state_s;
            pc_r     <= pc_s;
            instr_r  <= instr_s;
            valid_r  <= valid_s;
            count_r  <= count_s;
            busy_r   <= busy_s;
            halted_r <= halted_s;
        end
    end

    // Program memory write port; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem_r[prog_addr] <= prog_data;
        end
    end

    assign instr        = instr_r;
    assign instr_valid  = valid_r;
    assign pc           = pc_r;
    assign busy         = busy_r;
    assign halted       = halted_r;
    assign issued_count = count_r;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch_unit
//
// Self-checking bench for instr_fetch_unit. Expected instructions are pushed
// to a queue when a run is started and popped whenever the DUT hands an
// instruction over (valid & ready & no branch at the coming edge).
// -----------------------------------------------------------------------------
module tb_instr_fetch_unit;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 8;

    logic              clk;
    logic              rst_n;
    logic              start;
    logic              prog_we;
    logic [ADDR_W-1:0] prog_addr;
    logic [DATA_W-1:0] prog_data;
    logic              instr_ready;
    logic              branch_en;
    logic [ADDR_W-1:0] branch_addr;
    logic [DATA_W-1:0] instr;
    logic              instr_valid;
    logic [ADDR_W-1:0] pc;
    logic              busy;
    logic              halted;
    logic [7:0]        issued_count;

    int          n_tests;
    int          n_fail;
    logic [7:0]  exp_q [$];
    logic        last_acc;
    int          acc_n;

    instr_fetch_unit dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .prog_we      (prog_we),
        .prog_addr    (prog_addr),
        .prog_data    (prog_data),
        .instr_ready  (instr_ready),
        .branch_en    (branch_en),
        .branch_addr  (branch_addr),
        .instr        (instr),
        .instr_valid  (instr_valid),
        .pc           (pc),
        .busy         (busy),
        .halted       (halted),
        .issued_count (issued_count)
    );

    // Free-running clock, 10 time-unit period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard time limit so the bench can never hang.
    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock: score the handover about to happen, then advance to 1 unit
    // past the rising edge where outputs are stable.
    task automatic step();
        logic       acc;
        logic [7:0] e;
        acc = instr_valid && instr_ready && !branch_en;
        if (acc) begin
            if (exp_q.size() == 0) begin
                check_val("sb_unexpected_instr", 32'(instr), 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                check_val("sb_instr", 32'(instr), 32'(e));
            end
        end else if (!instr_valid) begin
            check_val("nop_when_invalid", 32'(instr), 32'hFF);
        end
        @(posedge clk);
        #1;
        last_acc = acc;
    endtask

    task automatic write_mem(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        prog_we   = 1'b1;
        prog_addr = a;
        prog_data = d;
        step();
        prog_we   = 1'b0;
    endtask

    task automatic run_until_halted(input int bound);
        for (int i = 0; i < bound && !halted; i++) step();
        check_val("halt_reached", 32'(halted), 32'd1);
    endtask

    task automatic run_until_count(input logic [7:0] target, input int bound);
        for (int i = 0; i < bound && issued_count != target; i++) step();
        check_val("count_reached", 32'(issued_count), 32'(target));
    endtask

    task automatic do_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_tests = 0; n_fail = 0; acc_n = 0; last_acc = 1'b0;
        rst_n = 1'b0; start = 1'b0; prog_we = 1'b0; prog_addr = '0; prog_data = '0;
        instr_ready = 1'b0; branch_en = 1'b0; branch_addr = '0;
        #12;
        check_val("rst_instr", 32'(instr), 32'hFF);
        check_val("rst_valid", 32'(instr_valid), 32'd0);
        check_val("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // 1: load program and run to HALT.
        write_mem(5'd0, 8'h00);
        write_mem(5'd1, 8'h01);
        write_mem(5'd2, 8'h0C);
        write_mem(5'd3, 8'h13);
        exp_q.push_back(8'h00); exp_q.push_back(8'h01);
        exp_q.push_back(8'h0C); exp_q.push_back(8'h13);
        instr_ready = 1'b1;
        do_start();
        check_val("t1_busy_after_start", 32'(busy), 32'd1);
        check_val("t1_valid_after_1_edge", 32'(instr_valid), 32'd0);
        check_val("t1_pc_start", 32'(pc), 32'd0);
        step();
        check_val("t1_valid_after_2_edges", 32'(instr_valid), 32'd1);
        check_val("t1_first_instr", 32'(instr), 32'h00);
        run_until_halted(20);
        check_val("t1_pc_at_halt", 32'(pc), 32'd3);
        check_val("t1_count", 32'(issued_count), 32'd4);
        check_val("t1_busy", 32'(busy), 32'd0);
        check_val("t1_valid", 32'(instr_valid), 32'd0);
        check_val("t1_queue_drained", 32'(exp_q.size()), 32'd0);

        // 2: backpressure, with an ignored program write while busy.
        instr_ready = 1'b0;
        exp_q.push_back(8'h00); exp_q.push_back(8'h01);
        exp_q.push_back(8'h0C); exp_q.push_back(8'h13);
        do_start();
        step();
        prog_we = 1'b1; prog_addr = 5'd1; prog_data = 8'h55;
        for (int i = 0; i < 5; i++) begin
            step();
            prog_we = 1'b0;
            check_val("t2_hold_instr", 32'(instr), 32'h00);
            check_val("t2_hold_valid", 32'(instr_valid), 32'd1);
            check_val("t2_hold_pc", 32'(pc), 32'd0);
            check_val("t2_hold_count", 32'(issued_count), 32'd0);
        end
        instr_ready = 1'b1;
        step();
        instr_ready = 1'b0;
        check_val("t2_one_accept", 32'(issued_count), 32'd1);
        step();
        for (int i = 0; i < 3; i++) begin
            step();
            check_val("t2_mem1_unchanged", 32'(instr), 32'h01);
            check_val("t2_count_held", 32'(issued_count), 32'd1);
        end
        instr_ready = 1'b1;
        run_until_halted(20);
        check_val("t2_count", 32'(issued_count), 32'd4);

        // 6: restart from HALTED runs the unchanged program from pc 0.
        exp_q.push_back(8'h00); exp_q.push_back(8'h01);
        exp_q.push_back(8'h0C); exp_q.push_back(8'h13);
        do_start();
        check_val("t6_restart_pc", 32'(pc), 32'd0);
        check_val("t6_restart_count", 32'(issued_count), 32'd0);
        check_val("t6_restart_busy", 32'(busy), 32'd1);
        run_until_halted(20);
        check_val("t6_count", 32'(issued_count), 32'd4);
        check_val("t6_queue_drained", 32'(exp_q.size()), 32'd0);

        // 3: branch during ISSUE drops the held instruction.
        for (int i = 0; i < 32; i++) write_mem(5'(i), 8'(8'h40 + i));
        exp_q.push_back(8'h40); exp_q.push_back(8'h41);
        do_start();
        run_until_count(8'd2, 20);
        step();
        check_val("t3_issue_valid", 32'(instr_valid), 32'd1);
        check_val("t3_issue_instr", 32'(instr), 32'h42);
        branch_en = 1'b1; branch_addr = 5'd5;
        step();
        branch_en = 1'b0;
        check_val("t3_count_unchanged", 32'(issued_count), 32'd2);
        check_val("t3_pc_redirect", 32'(pc), 32'd5);
        check_val("t3_valid_dropped", 32'(instr_valid), 32'd0);
        exp_q.push_back(8'h45); exp_q.push_back(8'h46);
        run_until_count(8'd4, 20);
        check_val("t3_pc_after", 32'(pc), 32'd7);
        check_val("t3_queue_drained", 32'(exp_q.size()), 32'd0);

        // 5: asynchronous reset mid-ISSUE, then the same program reruns.
        instr_ready = 1'b0;
        for (int i = 0; i < 4 && !instr_valid; i++) step();
        check_val("t5_in_issue", 32'(instr_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("t5_rst_instr", 32'(instr), 32'hFF);
        check_val("t5_rst_valid", 32'(instr_valid), 32'd0);
        check_val("t5_rst_pc", 32'(pc), 32'd0);
        check_val("t5_rst_busy", 32'(busy), 32'd0);
        check_val("t5_rst_halted", 32'(halted), 32'd0);
        check_val("t5_rst_count", 32'(issued_count), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_val("t5_idle_busy", 32'(busy), 32'd0);
        exp_q.push_back(8'h40); exp_q.push_back(8'h41);
        instr_ready = 1'b1;
        do_start();
        run_until_count(8'd2, 20);
        check_val("t5_queue_drained", 32'(exp_q.size()), 32'd0);

        // 4: no HALT anywhere: PC wrap and count saturation over 300 handovers.
        do_reset();
        for (int i = 0; i < 32; i++) write_mem(5'(i), 8'h00);
        for (int i = 0; i < 300; i++) exp_q.push_back(8'h00);
        acc_n = 0;
        do_start();
        for (int i = 0; i < 800 && acc_n < 300; i++) begin
            step();
            if (last_acc) begin
                acc_n++;
                check_val("t4_pc_wrap", 32'(pc), 32'(acc_n % 32));
                check_val("t4_count_sat", 32'(issued_count), 32'((acc_n > 255) ? 255 : acc_n));
            end
        end
        check_val("t4_accept_total", 32'(acc_n), 32'd300);
        check_val("t4_final_count", 32'(issued_count), 32'd255);
        check_val("t4_queue_drained", 32'(exp_q.size()), 32'd0);
        check_val("t4_not_halted", 32'(halted), 32'd0);
        do_reset();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
